// File: rtl/uop_issue_queue_pkg.sv
// Shared instruction and issue-queue definitions for the uop issue queue slice.
// The uop_issue_queue feature macro IQ_SHOOTDOWN_EN (branch-tag kill) is used by the top.
package uop_issue_queue_pkg;

  localparam int NUM_PREGS              = 64;
  localparam int PREG_W                 = $clog2(NUM_PREGS);
  localparam int ROB_ENTRIES            = 32;
  localparam int ROB_W                  = $clog2(ROB_ENTRIES);
  localparam int MAX_PREDICT_DEPTH_BITS = 3;
  localparam int IQ_ENTRIES_DEF         = 8;
  localparam int WB_PORTS_DEF           = 2;

  typedef logic [PREG_W-1:0]                 preg_t;
  typedef logic [ROB_W-1:0]                  rob_idx_t;
  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] br_tag_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] imm;
  } decoded_instruction;

  typedef struct packed {
    rob_idx_t idx;
    logic     valid;
  } rob;

  typedef struct packed {
    decoded_instruction instr;
    preg_t              dest;
    preg_t              src_a;
    logic               src_a_rdy;
    preg_t              src_b;
    logic               src_b_rdy;
    rob_idx_t           rob_idx;
    br_tag_t            br_tag;
  } iq_entry;

  function automatic logic both_ready(input iq_entry e);
    return e.src_a_rdy & e.src_b_rdy;
  endfunction

endpackage

// File: rtl/uop_issue_queue_select.sv
// iq_select: oldest-ready picker; lowest set request bit wins, returned one-hot and encoded.
module iq_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Isolate the lowest set bit, then OR-encode the one-hot grant.
  always_comb begin
    grant = req & (~req + N'(1));
    any   = |req;
    idx   = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = idx | (grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

endmodule

// File: rtl/uop_issue_queue.sv
// Compacting uop issue queue: pairwise enqueue, writeback wakeup, oldest-ready select.
// Optional branch-tag kill is compiled in when IQ_SHOOTDOWN_EN is defined.
module uop_issue_queue
  import uop_issue_queue_pkg::*;
#(
  parameter int IQ_ENTRIES = IQ_ENTRIES_DEF,
  parameter int WB_PORTS   = WB_PORTS_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  enabled,
  input  logic [1:0]                            enq_valid,
  input  iq_entry                               enq_entry_1,
  input  iq_entry                               enq_entry_2,
  output logic                                  stalled,
  input  logic [WB_PORTS-1:0]                   wb_valid,
  input  logic [WB_PORTS-1:0][PREG_W-1:0]       wb_preg,
  input  logic                                  branch_shootdown,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0]     shootdown_branch_tag,
  output logic                                  out_valid,
  output iq_entry                               out_entry,
  input  logic                                  out_ready,
  output logic [$clog2(IQ_ENTRIES):0]           num_used
);

  localparam int IDX_W = $clog2(IQ_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  iq_entry                 ent_r [IQ_ENTRIES];
  logic [IQ_ENTRIES-1:0]   vld_r;
  logic [CNT_W-1:0]        count_r;
  logic                    out_valid_r;
  iq_entry                 out_entry_r;

  iq_entry                 ent_nxt_s [IQ_ENTRIES];
  logic [IQ_ENTRIES-1:0]   vld_nxt_s;
  logic [CNT_W-1:0]        pos_s;
  logic [IQ_ENTRIES-1:0]   kill_s;
  logic [IQ_ENTRIES-1:0]   req_s;
  logic [IQ_ENTRIES-1:0]   grant_s;
  logic [IDX_W-1:0]        sel_idx_s;
  logic                    sel_any_s;
  logic                    out_kill_s;
  logic                    sel_fire_s;
  logic                    accept_s;

  function automatic iq_entry wake(input iq_entry e,
                                   input logic [WB_PORTS-1:0] v,
                                   input logic [WB_PORTS-1:0][PREG_W-1:0] p);
    iq_entry w;
    w = e;
    for (int k = 0; k < WB_PORTS; k++) begin
      w.src_a_rdy = w.src_a_rdy | (v[k] & (p[k] == e.src_a));
      w.src_b_rdy = w.src_b_rdy | (v[k] & (p[k] == e.src_b));
    end
    return w;
  endfunction

`ifdef IQ_SHOOTDOWN_EN
  // Tag-match kill for the array and the output register.
  always_comb begin
    kill_s = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      kill_s[i] = branch_shootdown & vld_r[i] & (ent_r[i].br_tag == shootdown_branch_tag);
    end
    out_kill_s = branch_shootdown & out_valid_r & (out_entry_r.br_tag == shootdown_branch_tag);
  end
`else
  logic unused_shootdown_s;
  assign kill_s             = '0;
  assign out_kill_s         = 1'b0;
  assign unused_shootdown_s = ^{branch_shootdown, shootdown_branch_tag};
`endif

  // Eligibility uses registered ready bits, so a wakeup takes effect one cycle later.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      req_s[i] = vld_r[i] & ~kill_s[i] & both_ready(ent_r[i]);
    end
  end

  iq_select #(.N(IQ_ENTRIES), .IDX_W(IDX_W)) u_select (
    .req   (req_s),
    .grant (grant_s),
    .idx   (sel_idx_s),
    .any   (sel_any_s)
  );

  assign stalled    = (count_r > CNT_W'(IQ_ENTRIES - 2));
  assign accept_s   = enabled & ~stalled;
  assign sel_fire_s = sel_any_s & (~out_valid_r | out_ready | out_kill_s);

  // Compact survivors toward index 0, then append the accepted pair with bypass wakeup.
  always_comb begin
    pos_s     = '0;
    vld_nxt_s = '0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      ent_nxt_s[i] = '0;
    end
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      if (vld_r[i] && !kill_s[i] && !(sel_fire_s && grant_s[i])) begin
        ent_nxt_s[pos_s[IDX_W-1:0]] = wake(ent_r[i], wb_valid, wb_preg);
        vld_nxt_s[pos_s[IDX_W-1:0]] = 1'b1;
        pos_s = pos_s + CNT_W'(1);
      end else begin
        pos_s = pos_s;
      end
    end
    if (accept_s && enq_valid[0]) begin
      ent_nxt_s[pos_s[IDX_W-1:0]] = wake(enq_entry_1, wb_valid, wb_preg);
      vld_nxt_s[pos_s[IDX_W-1:0]] = 1'b1;
      pos_s = pos_s + CNT_W'(1);
    end else begin
      pos_s = pos_s;
    end
    if (accept_s && enq_valid[1]) begin
      ent_nxt_s[pos_s[IDX_W-1:0]] = wake(enq_entry_2, wb_valid, wb_preg);
      vld_nxt_s[pos_s[IDX_W-1:0]] = 1'b1;
      pos_s = pos_s + CNT_W'(1);
    end else begin
      pos_s = pos_s;
    end
  end

  // Payload storage; slots are only meaningful under their valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      ent_r[i] <= ent_nxt_s[i];
    end
  end

  // Control state: reset beats clear, clear beats enqueue and select.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r       <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_entry_r <= '0;
    end else if (clear) begin
      vld_r       <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_entry_r <= '0;
    end else begin
      vld_r   <= vld_nxt_s;
      count_r <= pos_s;
      if (sel_fire_s) begin
        out_valid_r <= 1'b1;
        out_entry_r <= ent_r[sel_idx_s];
      end else begin
        out_valid_r <= out_valid_r & ~out_ready & ~out_kill_s;
        out_entry_r <= out_entry_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_entry = out_entry_r;
  assign num_used  = count_r;

endmodule
